// File: rtl/sound_latch_irq.sv
// 68000-to-Z80 sound command latch with a periodic Z80 timer interrupt.
// Define SND_LATCH_FIFO_EN to replace the single latch with a 4-entry FIFO.
module sound_latch_irq #(
    parameter int unsigned TIMER_DIV = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        z80_cen,
    input  logic [15:0] m68k_din,
    input  logic        m68k_rw,
    input  logic        m68k_lds_n,
    input  logic        sound_latch_cs,
    input  logic        z80_latch_r_cs,
    input  logic        z80_latch_clr_cs,
    input  logic        M1_n,
    input  logic        IORQ_n,
    output logic [7:0]  latch_dout,
    output logic        latch_valid,
    output logic        z80_irq_n
);

    logic        wr, ack;
    logic        wr_edge, clr_edge, rd_end, ack_edge, tick;
    logic        wr_prev_q, clr_prev_q, rd_prev_q, ack_prev_q;
    logic [15:0] tcnt_q, tcnt_d;
    logic        irq_pend_q, irq_pend_d;
    logic        unused_din_hi;

    assign unused_din_hi = ^m68k_din[15:8];

    assign wr       = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    assign ack      = ~M1_n & ~IORQ_n;
    assign wr_edge  = wr & ~wr_prev_q;
    assign clr_edge = z80_latch_clr_cs & ~clr_prev_q;
    assign rd_end   = ~z80_latch_r_cs & rd_prev_q;
    assign ack_edge = ack & ~ack_prev_q;
    assign tick     = z80_cen & (tcnt_q == 16'(TIMER_DIV - 1));

    // History clears on reset so a strobe held through reset counts as a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_prev_q  <= 1'b0;
            clr_prev_q <= 1'b0;
            rd_prev_q  <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            wr_prev_q  <= wr;
            clr_prev_q <= z80_latch_clr_cs;
            rd_prev_q  <= z80_latch_r_cs;
            ack_prev_q <= ack;
        end
    end

    always_comb begin
        tcnt_d     = tcnt_q;
        irq_pend_d = irq_pend_q;
        if (z80_cen) begin
            tcnt_d = tick ? '0 : tcnt_q + 16'd1;
        end
        if (ack_edge) begin
            irq_pend_d = 1'b0;
        end
        if (tick) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q     <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            tcnt_q     <= tcnt_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign z80_irq_n = ~irq_pend_q;

`ifdef SND_LATCH_FIFO_EN
    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       push, pop;

    assign push = wr_edge & (cnt_q != 3'd4);
    assign pop  = rd_end & (cnt_q != 3'd0);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_edge) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = m68k_din[7:0];
                wptr_d        = wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_d = rptr_q + 2'd1;
            end
            cnt_d = cnt_q + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign latch_dout  = (cnt_q == 3'd0) ? 8'h00 : mem_q[rptr_q];
    assign latch_valid = (cnt_q != 3'd0);
`else
    logic [7:0] latch_q, latch_d;
    logic       valid_q, valid_d;

    // Clear beats write; write beats read-end so a fresh command stays flagged.
    always_comb begin
        latch_d = latch_q;
        valid_d = valid_q;
        if (clr_edge) begin
            latch_d = '0;
            valid_d = 1'b0;
        end else if (wr_edge) begin
            latch_d = m68k_din[7:0];
            valid_d = 1'b1;
        end else if (rd_end) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= '0;
            valid_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
            valid_q <= valid_d;
        end
    end

    assign latch_dout  = latch_q;
    assign latch_valid = valid_q;
`endif

endmodule

// File: tb/tb_sound_latch_irq.sv
// Directed self-checking bench for sound_latch_irq (single-latch build, TIMER_DIV=4).
module tb_sound_latch_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic        z80_cen;
    logic [15:0] m68k_din;
    logic        m68k_rw;
    logic        m68k_lds_n;
    logic        sound_latch_cs;
    logic        z80_latch_r_cs;
    logic        z80_latch_clr_cs;
    logic        M1_n;
    logic        IORQ_n;
    logic [7:0]  latch_dout;
    logic        latch_valid;
    logic        z80_irq_n;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    sound_latch_irq #(.TIMER_DIV(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .z80_cen          (z80_cen),
        .m68k_din         (m68k_din),
        .m68k_rw          (m68k_rw),
        .m68k_lds_n       (m68k_lds_n),
        .sound_latch_cs   (sound_latch_cs),
        .z80_latch_r_cs   (z80_latch_r_cs),
        .z80_latch_clr_cs (z80_latch_clr_cs),
        .M1_n             (M1_n),
        .IORQ_n           (IORQ_n),
        .latch_dout       (latch_dout),
        .latch_valid      (latch_valid),
        .z80_irq_n        (z80_irq_n)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cen_pulse();
        z80_cen = 1'b1;
        step();
        z80_cen = 1'b0;
        step();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        sound_latch_cs = 1'b0;
        m68k_rw        = 1'b1;
        m68k_lds_n     = 1'b1;
    endtask

    task automatic start_write(input logic [15:0] d);
        m68k_din       = d;
        sound_latch_cs = 1'b1;
        m68k_rw        = 1'b0;
        m68k_lds_n     = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        z80_cen          = 1'b0;
        m68k_din         = 16'h0000;
        z80_latch_r_cs   = 1'b0;
        z80_latch_clr_cs = 1'b0;
        M1_n             = 1'b1;
        IORQ_n           = 1'b1;
        idle_bus();
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_dout", 16'(latch_dout), 16'h00);
        check("rst_valid", 16'(latch_valid), 16'h0);
        check("rst_irq_n", 16'(z80_irq_n), 16'h1);

        // Held write: only the first high cycle registers.
        start_write(16'h12A5);
        step();
        check("wr_dout", 16'(latch_dout), 16'hA5);
        check("wr_valid", 16'(latch_valid), 16'h1);
        m68k_din = 16'h0077;
        repeat (5) step();
        check("held_no_rewrite", 16'(latch_dout), 16'hA5);
        idle_bus();
        step();

        z80_latch_clr_cs = 1'b1;
        step();
        check("clr_dout", 16'(latch_dout), 16'h00);
        check("clr_valid", 16'(latch_valid), 16'h0);
        z80_latch_clr_cs = 1'b0;
        step();

        // Strobes that do not qualify as a write.
        start_write(16'h0055);
        m68k_lds_n = 1'b1;
        repeat (2) step();
        check("lds_hi_dout", 16'(latch_dout), 16'h00);
        check("lds_hi_valid", 16'(latch_valid), 16'h0);
        m68k_lds_n = 1'b0;
        m68k_rw    = 1'b1;
        repeat (2) step();
        check("rw_hi_dout", 16'(latch_dout), 16'h00);
        check("rw_hi_valid", 16'(latch_valid), 16'h0);
        idle_bus();
        step();

        // Read pulse keeps data, drops valid at end of read.
        start_write(16'h0033);
        step();
        idle_bus();
        step();
        z80_latch_r_cs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd_dout_hold", 16'(latch_dout), 16'h33);
            check("rd_valid_hold", 16'(latch_valid), 16'h1);
        end
        z80_latch_r_cs = 1'b0;
        step();
        check("rd_end_valid", 16'(latch_valid), 16'h0);
        check("rd_end_dout", 16'(latch_dout), 16'h33);
        z80_latch_clr_cs = 1'b1;
        step();
        check("clr2_dout", 16'(latch_dout), 16'h00);
        z80_latch_clr_cs = 1'b0;
        step();

        // Write and clear together: clear wins.
        start_write(16'h0044);
        z80_latch_clr_cs = 1'b1;
        step();
        check("wr_clr_dout", 16'(latch_dout), 16'h00);
        check("wr_clr_valid", 16'(latch_valid), 16'h0);
        idle_bus();
        z80_latch_clr_cs = 1'b0;
        step();

        // Write and read end together: write wins.
        start_write(16'h0011);
        step();
        idle_bus();
        z80_latch_r_cs = 1'b1;
        step();
        start_write(16'h0022);
        z80_latch_r_cs = 1'b0;
        step();
        check("wr_rdend_dout", 16'(latch_dout), 16'h22);
        check("wr_rdend_valid", 16'(latch_valid), 16'h1);
        idle_bus();
        step();

        // Timer: cen every 2nd clk, IRQ after 4th cen.
        repeat (3) cen_pulse();
        check("irq_before_4th", 16'(z80_irq_n), 16'h1);
        z80_cen = 1'b1;
        step();
        check("irq_after_4th", 16'(z80_irq_n), 16'h0);
        z80_cen = 1'b0;
        step();
        repeat (2) cen_pulse();
        check("irq_held", 16'(z80_irq_n), 16'h0);
        M1_n   = 1'b0;
        IORQ_n = 1'b0;
        step();
        check("irq_ack_release", 16'(z80_irq_n), 16'h1);
        step();
        check("irq_ack_held_no_refire", 16'(z80_irq_n), 16'h1);
        M1_n   = 1'b1;
        IORQ_n = 1'b1;
        step();
        cen_pulse();
        check("irq_before_period", 16'(z80_irq_n), 16'h1);
        z80_cen = 1'b1;
        step();
        check("irq_period", 16'(z80_irq_n), 16'h0);
        z80_cen = 1'b0;
        step();

        // Ack edge coinciding with a tick: IRQ stays pending.
        repeat (3) cen_pulse();
        z80_cen = 1'b1;
        M1_n    = 1'b0;
        IORQ_n  = 1'b0;
        step();
        check("ack_tick_same", 16'(z80_irq_n), 16'h0);
        z80_cen = 1'b0;
        M1_n    = 1'b1;
        IORQ_n  = 1'b1;
        step();
        check("ack_tick_after", 16'(z80_irq_n), 16'h0);

        // Reset while pending; period restarts from zero.
        cen_pulse();
        reset = 1'b1;
        step();
        check("rst_pend_irq_n", 16'(z80_irq_n), 16'h1);
        check("rst_pend_dout", 16'(latch_dout), 16'h00);
        check("rst_pend_valid", 16'(latch_valid), 16'h0);
        reset = 1'b0;
        step();
        repeat (3) cen_pulse();
        check("restart_before_4th", 16'(z80_irq_n), 16'h1);
        z80_cen = 1'b1;
        step();
        check("restart_after_4th", 16'(z80_irq_n), 16'h0);
        z80_cen = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
